dmem_responder: RTL

Data-memory responder for the single-cycle MIPS core: the memory-side end of the core's CEN/WEN/OEN/A/Data2Mem/ReadDataMem port. It holds a 128×32 word array and answers reads combinationally within the core's cycle. It posts writes through a one-entry write buffer that forwards to later reads, and zero-fills the array after reset while reporting busy. It sits beside the core in the top-level testbench/SoC, in place of a behavioural SRAM model.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_wbuf.sv | 50 +++++
 rtl/dmem_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared defaults and state encoding for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 128;
  localparam int DMEM_CNT_W  = 16;

  // CLEAR sweeps the array to zero after reset; RUN serves the core.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer with a commit strobe and NPORT forwarding
// lookups, so every read path sees a buffered write before it reaches the array.
module dmem_wbuf #(
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int NPORT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [AW-1:0]              ld_addr,
  input  logic [DW-1:0]              ld_data,
  output logic                       commit,
  output logic [AW-1:0]              cm_addr,
  output logic [DW-1:0]              cm_data,
  input  logic [NPORT-1:0][AW-1:0]   lk_addr,
  input  logic [NPORT-1:0][DW-1:0]   lk_mem,
  output logic [NPORT-1:0][DW-1:0]   lk_data
);

  logic          vld;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  // Entry holds for exactly one cycle: a new write replaces it, otherwise it drains.
  // Reset drops a pending entry without committing it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      addr <= ld_addr;
      data <= ld_data;
    end else begin
      vld  <= 1'b0;
    end
  end

  // A valid entry is written to the array on every edge it is present.
  assign commit  = vld;
  assign cm_addr = addr;
  assign cm_data = data;

  for (genvar i = 0; i < NPORT; i++) begin : g_lk
    assign lk_data[i] = (vld && addr == lk_addr[i]) ? data : lk_mem[i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle MIPS core: 128x32 array,
// combinational reads, posted writes with forwarding, post-reset clear sweep.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int CNT_W  = DMEM_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e              state, state_nx;
  logic [ADDR_W-1:0]   clr_ptr;
  logic                run, clr_we;
  logic                rd, wr, acc, ill, err_set;
  logic                commit;
  logic [ADDR_W-1:0]   cm_addr;
  logic [DATA_W-1:0]   cm_data;
  logic [1:0][ADDR_W-1:0] lk_addr;
  logic [1:0][DATA_W-1:0] lk_mem, lk_data;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Port decode: only clean read or write strobes in RUN are served.
  assign acc     = !CEN && (!WEN || !OEN);
  assign ill     = !CEN && !WEN && !OEN;
  assign rd      = run && !CEN && !OEN && WEN;
  assign wr      = run && !CEN && !WEN && OEN;
  assign err_set = ill || (!run && acc);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_nx;
  end

  // Leave CLEAR on the same edge that clears the last word.
  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_ptr == ADDR_W'(DEPTH - 1)) state_nx = RUN;
  end

  // State-derived outputs.
  always_comb begin
    run    = (state == RUN);
    busy   = (state == CLEAR);
    clr_we = (state == CLEAR);
  end

  // Sweep pointer walks the array once per reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         clr_ptr <= '0;
    else if (clr_we) clr_ptr <= clr_ptr + ADDR_W'(1);
  end

  // Array write port: clear sweep, or drain of the buffered write.
  always_ff @(posedge clk) begin
    if (clr_we)      mem[clr_ptr] <= '0;
    else if (commit) mem[cm_addr] <= cm_data;
  end

  assign lk_addr[0] = A;
  assign lk_addr[1] = dbg_addr;
  assign lk_mem[0]  = mem[A];
  assign lk_mem[1]  = mem[dbg_addr];

  dmem_wbuf #(.AW(ADDR_W), .DW(DATA_W), .NPORT(2)) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .load    (wr),
    .ld_addr (A),
    .ld_data (D),
    .commit  (commit),
    .cm_addr (cm_addr),
    .cm_data (cm_data),
    .lk_addr (lk_addr),
    .lk_mem  (lk_mem),
    .lk_data (lk_data)
  );

  assign Q        = rd ? lk_data[0] : '0;
  assign dbg_data = lk_data[1];

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Saturating access counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd && rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
      if (wr && wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
    end
  end

endmodule
